wallace_reduce_pl: RTL and testbench
====================================

WALLACE_REDUCE_PL -- requirements
Module: wallace_reduce_pl

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits and product width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  the operand pair is presented this cycle.
REQ-005 in_ready  output  1  the block accepts the operand pair this cycle.
REQ-006 op_x  input  8  unsigned multiplicand.
REQ-007 op_y  input  8  unsigned multiplier.
REQ-008 out_valid  output  1  out_a, out_b and out_kin are valid.
REQ-009 out_ready  input  1  the downstream 16-bit KPG adder stage consumes this cycle.
REQ-010 out_a  output  16  first reduced row, which feeds adder operand a.
REQ-011 out_b  output  16  second reduced row, which feeds adder operand b.
REQ-012 out_kin  output  2  KPG carry-in for the adder; always 2'b00 (kill).
REQ-013 busy  output  1  at least one pipeline stage holds valid data.

Function
REQ-014 The block SHALL guarantee out_a + out_b (mod 2^16) = op_x * op_y for every accepted pair.
REQ-015 Stage S1 SHALL register the 64 AND partial products after two 3:2 carry-save levels.
- Valid bit: v1.
REQ-016 Stage S2 SHALL complete the reduction to two rows and register them.
- Valid bit: v2.
- Without the output stage, S2 drives out_a and out_b.
REQ-017 Each stage SHALL load when its valid bit is 0 or its contents are consumed in the same cycle.
- Otherwise the stage holds its data and valid bit unchanged.
REQ-018 A stage SHALL NOT change its data while its valid bit is 1 and the next stage does not consume.
REQ-019 in_ready SHALL equal !v1 | (S1 contents advance this cycle).
- in_ready is combinational from out_ready.
- This gives full throughput: one pair accepted per cycle when out_ready=1.
REQ-020 Latency SHALL be 2 cycles from acceptance to out_valid, or 3 with WALLACE_OUTREG_EN.
REQ-021 With out_ready held 0, the pipeline SHALL fill completely, then deassert in_ready.
- No accepted pair is lost or duplicated.
REQ-022 When the last stage is consumed and in_valid=1 in the same cycle, both SHALL occur.
- The pipeline shifts with no bubble.
REQ-023 When in_valid=0, S1 SHALL load v1=0 if it is free; the data content is don't-care.
REQ-024 busy SHALL be the OR of all stage valid bits.
REQ-025 out_a and out_b SHALL hold their values while out_valid=1 and out_ready=0.

Reset
REQ-026 Asserting rst SHALL clear all valid bits asynchronously.
- out_valid=0, busy=0, out_a=0, out_b=0.
- in_ready becomes 1 in the first cycle after reset deasserts.
REQ-027 Asserting rst mid-operation SHALL discard all in-flight pairs; none appears after reset.
REQ-028 out_kin SHALL be 2'b00 in reset and at all other times.

Configuration
REQ-029 Macro WALLACE_OUTREG_EN defined: a third register stage S3 (valid bit v3) SHALL be added after S2.
- S3 drives the outputs; latency is 3 cycles.
- S3 follows the REQ-017 handshake.
REQ-030 Macro WALLACE_OUTREG_EN undefined: S3 SHALL be absent; latency is 2 cycles.
- Throughput and all other behaviour are identical.

Structure
REQ-031 Package wallace_pkg SHALL hold the shared definitions:
- OP_W=8, PROD_W=16, KPG_KILL=2'b00, KPG_PROP=2'b01, KPG_GEN=2'b10.
- The row typedef logic [PROD_W-1:0].
REQ-032 Sub-module csa_row (a 3:2 carry-save compressor over PROD_W bits) SHALL be instantiated for every reduction level.
REQ-033 No adder carry propagation SHALL occur inside the block; final addition belongs to the downstream KPG adder.

Verification
REQ-034 Directed scenarios:
- Max values: op_x=8'hFF, op_y=8'hFF, out_ready=1.
  -> After 2 cycles (3 with the macro), out_valid=1 and out_a+out_b=16'hFE01.
- Zero operand: op_x=8'h00, op_y=8'hA5.
  -> out_a+out_b=16'h0000, out_kin=2'b00.
- Back-to-back stream: pairs (3,5), (12,12), (200,2) on consecutive cycles, out_ready=1.
  -> Sums 15, 144, 400 on consecutive cycles; in_ready stays 1.
- Stall: out_ready=0 for 5 cycles while in_valid=1.
  -> in_ready falls after 2 (or 3) acceptances.
  -> Outputs stay stable.
  -> After release, all pairs emerge in order with no loss.
- Mid-operation reset: rst pulsed for 1 cycle with 2 pairs in flight.
  -> out_valid=0 and busy=0 immediately.
  -> No stale result appears afterwards.
- Exhaustive sweep: all 65536 operand pairs with random out_ready.
  -> Every out_a+out_b mod 2^16 matches the reference product.
  -> Ordering is preserved.

Source files
------------

// File: rtl/wallace_pkg.sv
// wallace_pkg: shared widths, KPG carry encodings and the partial-product row type
package wallace_pkg;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam logic [1:0] KPG_KILL = 2'b00;
   localparam logic [1:0] KPG_PROP = 2'b01;
   localparam logic [1:0] KPG_GEN  = 2'b10;
   typedef logic [PROD_W-1:0] row_t;
endpackage

// File: rtl/csa_row.sv
// csa_row: 3:2 carry-save compressor across one product-width row, carries shifted into weight position
module csa_row
   import wallace_pkg::*;
(
   input  row_t a,
   input  row_t b,
   input  row_t c,
   output row_t s,
   output row_t co
);
   assign s  = a ^ b ^ c;
   assign co = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/wallace_reduce_pl.sv
// wallace_reduce_pl: pipelined 8x8 Wallace reduction to two rows for a KPG adder; WALLACE_OUTREG_EN adds output stage S3
module wallace_reduce_pl
   import wallace_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op_x,
   input  logic [OP_W-1:0] op_y,
   output logic            out_valid,
   input  logic            out_ready,
   output row_t            out_a,
   output row_t            out_b,
   output logic [1:0]      out_kin,
   output logic            busy
);
   row_t pp [OP_W];
   row_t l1 [6];
   row_t l2 [4];
   row_t m  [3];
   row_t fs, fc;
   row_t r1_d [4];
   row_t r1_q [4];
   row_t a2_d, b2_d, a2_q, b2_q;
   logic v1_d, v1_q, v2_d, v2_q, ld1, ld2;
`ifdef WALLACE_OUTREG_EN
   row_t a3_d, b3_d, a3_q, b3_q;
   logic v3_d, v3_q, ld3;
`endif

   // AND partial products, row i weighted by 2^i
   always_comb begin
      for (int i = 0; i < OP_W; i++) pp[i] = op_y[i] ? row_t'(op_x) << i : '0;
   end

   for (genvar k = 0; k < 2; k++) begin : g_l1
      csa_row u_csa (.a(pp[3*k]), .b(pp[3*k+1]), .c(pp[3*k+2]), .s(l1[2*k]), .co(l1[2*k+1]));
   end
   assign l1[4] = pp[6];
   assign l1[5] = pp[7];

   for (genvar k = 0; k < 2; k++) begin : g_l2
      csa_row u_csa (.a(l1[3*k]), .b(l1[3*k+1]), .c(l1[3*k+2]), .s(l2[2*k]), .co(l2[2*k+1]));
   end

   csa_row u_csa3 (.a(r1_q[0]), .b(r1_q[1]), .c(r1_q[2]), .s(m[0]), .co(m[1]));
   assign m[2] = r1_q[3];
   csa_row u_csa4 (.a(m[0]), .b(m[1]), .c(m[2]), .s(fs), .co(fc));

   // Backward-propagating load enables; data only moves when its source is valid
   always_comb begin
`ifdef WALLACE_OUTREG_EN
      ld3  = !v3_q | out_ready;
      ld2  = !v2_q | ld3;
      v3_d = ld3 ? v2_q : v3_q;
      a3_d = (ld3 && v2_q) ? a2_q : a3_q;
      b3_d = (ld3 && v2_q) ? b2_q : b3_q;
`else
      ld2  = !v2_q | out_ready;
`endif
      ld1  = !v1_q | ld2;
      v1_d = ld1 ? in_valid : v1_q;
      v2_d = ld2 ? v1_q : v2_q;
      for (int i = 0; i < 4; i++) r1_d[i] = (ld1 && in_valid) ? l2[i] : r1_q[i];
      a2_d = (ld2 && v1_q) ? fs : a2_q;
      b2_d = (ld2 && v1_q) ? fc : b2_q;
   end

   // Stage registers; reset empties the pipeline and zeroes the output rows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         r1_q <= '{default: '0};
         a2_q <= '0;
         b2_q <= '0;
`ifdef WALLACE_OUTREG_EN
         v3_q <= 1'b0;
         a3_q <= '0;
         b3_q <= '0;
`endif
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         r1_q <= r1_d;
         a2_q <= a2_d;
         b2_q <= b2_d;
`ifdef WALLACE_OUTREG_EN
         v3_q <= v3_d;
         a3_q <= a3_d;
         b3_q <= b3_d;
`endif
      end
   end

   assign in_ready = ld1;
   assign out_kin  = KPG_KILL;
`ifdef WALLACE_OUTREG_EN
   assign out_valid = v3_q;
   assign out_a     = a3_q;
   assign out_b     = b3_q;
   assign busy      = v1_q | v2_q | v3_q;
`else
   assign out_valid = v2_q;
   assign out_a     = a2_q;
   assign out_b     = b2_q;
   assign busy      = v1_q | v2_q;
`endif
endmodule

// File: tb/tb_wallace_reduce_pl.sv
// tb_wallace_reduce_pl: scoreboard bench, product reference model, directed and random stimulus
module tb_wallace_reduce_pl;
`ifdef WALLACE_OUTREG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [7:0] op_x = '0;
   logic [7:0] op_y = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [15:0] out_a, out_b;
   logic [1:0] out_kin;
   logic busy;

   typedef struct { logic [15:0] prod; int cyc; } exp_t;
   exp_t sb [$];
   int lat_q [$];
   int checks = 0;
   int fails = 0;
   int cyc = 0;

   wallace_reduce_pl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_x(op_x), .op_y(op_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_kin(out_kin), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic cycle_drive(input bit v, input logic [7:0] x, input logic [7:0] y, input bit r, output bit acc);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      op_x = x;
      op_y = y;
      out_ready = r;
      #1;
      acc = v && in_ready;
      if (acc) begin
         e.prod = 16'(int'(x) * int'(y));
         e.cyc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         cycle_drive(0, 8'h00, 8'h00, 1, acc);
         n++;
      end
      check("drain_timeout", 32'(n < 200), 32'd1);
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_lats(input string nm, input int n);
      check({nm, "_count"}, 32'(lat_q.size()), 32'(n));
      foreach (lat_q[i]) check({nm, "_lat"}, 32'(lat_q[i]), 32'(LAT));
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks hold behaviour under stall
   initial begin
      logic hold;
      logic [15:0] ha, hb, s;
      exp_t e;
      hold = 1'b0;
      ha = '0;
      hb = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) hold = 1'b0;
         else begin
            if (hold) begin
               check("hold_a", 32'(out_a), 32'(ha));
               check("hold_b", 32'(out_b), 32'(hb));
            end
            if (out_valid) check("kin", 32'(out_kin), 32'd0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_out: got a=%0h b=%0h required no output", out_a, out_b);
               end else begin
                  e = sb.pop_front();
                  s = out_a + out_b;
                  check("sum", 32'(s), 32'(e.prod));
                  lat_q.push_back(cyc - e.cyc);
                  check("lat_min", 32'(cyc - e.cyc >= LAT), 32'd1);
               end
            end
            hold = out_valid && !out_ready;
            ha = out_a;
            hb = out_b;
         end
      end
   end

   // Stimulus
   initial begin
      bit acc;
      int n;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_a", 32'(out_a), 32'd0);
      check("rst_out_b", 32'(out_b), 32'd0);
      check("rst_kin", 32'(out_kin), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      lat_q.delete();
      cycle_drive(1, 8'hFF, 8'hFF, 1, acc);
      check("max_acc", 32'(acc), 32'd1);
      drain();
      check_lats("max", 1);

      lat_q.delete();
      cycle_drive(1, 8'h00, 8'hA5, 1, acc);
      check("zero_acc", 32'(acc), 32'd1);
      drain();
      check_lats("zero", 1);

      lat_q.delete();
      cycle_drive(1, 8'd3, 8'd5, 1, acc);
      check("b2b_rdy0", 32'(acc), 32'd1);
      cycle_drive(1, 8'd12, 8'd12, 1, acc);
      check("b2b_rdy1", 32'(acc), 32'd1);
      cycle_drive(1, 8'd200, 8'd2, 1, acc);
      check("b2b_rdy2", 32'(acc), 32'd1);
      drain();
      check_lats("b2b", 3);

      n = 0;
      for (int i = 0; i < 5; i++) begin
         cycle_drive(1, 8'($urandom), 8'($urandom), 0, acc);
         if (acc) n++;
      end
      check("stall_accepts", 32'(n), 32'(LAT));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      drain();

      cycle_drive(1, 8'd7, 8'd9, 0, acc);
      cycle_drive(1, 8'd11, 8'd13, 0, acc);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_out_a", 32'(out_a), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 8; i++) cycle_drive(0, 8'h00, 8'h00, 1, acc);
      check("mid_rst_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 300; i++)
         cycle_drive(bit'($urandom_range(1)), 8'($urandom), 8'($urandom), bit'($urandom_range(1)), acc);
      drain();

      for (int i = 0; i < 65536; i++) begin
         n = 0;
         acc = 1'b0;
         while (!acc && n < 100) begin
            cycle_drive(1, 8'(i), 8'(i >> 8), ($urandom % 16) != 0, acc);
            n++;
         end
         if (!acc) begin
            check("sweep_accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
